// File: rtl/tournament_chooser.sv
// Tournament chooser: per-PC 2-bit saturating counters pick between a local
// and a global component prediction; an in-order FIFO of in-flight lookups
// trains the counters when branches resolve.
// Optional feature: define TOURNAMENT_CHOOSER_STATS_EN to add stat_mispred_o.
module tournament_chooser #(
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          pred_v_i,
    input  logic [31:0]                   pred_pc_i,
    input  logic                          local_pred_i,
    input  logic                          global_pred_i,
    output logic                          pred_ready_o,
    output logic                          pred_v_o,
    output logic                          pred_taken_o,
    input  logic                          resolve_v_i,
    input  logic                          resolve_taken_i,
    input  logic                          flush_i,
    output logic [$clog2(FIFO_DEPTH):0]   inflight_o,
`ifdef TOURNAMENT_CHOOSER_STATS_EN
    output logic [15:0]                   stat_mispred_o,
`endif
    output logic                          resolve_err_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NCTR = 1 << IDX_W;

    logic [1:0]       ctr [NCTR];
    logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
    logic             fifo_loc [FIFO_DEPTH];
    logic             fifo_glb [FIFO_DEPTH];
    logic             fifo_fin [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [IDX_W-1:0] idx;
    logic             final_pred;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] pop_idx;
    logic             pop_loc;
    logic             pop_glb;
    logic             unused_pc;

    assign idx        = pred_pc_i[IDX_W+1:2];
    assign unused_pc  = ^{pred_pc_i[31:IDX_W+2], pred_pc_i[1:0]};
    // Counter read uses the registered value; a same-cycle update is not forwarded.
    assign final_pred = ctr[idx][1] ? global_pred_i : local_pred_i;

    assign pred_ready_o = (inflight_o < CW'(FIFO_DEPTH));
    assign push    = pred_v_i & pred_ready_o & ~flush_i;
    assign pop     = resolve_v_i & (inflight_o != '0) & ~flush_i;
    assign pop_idx = fifo_idx[rd_ptr];
    assign pop_loc = fifo_loc[rd_ptr];
    assign pop_glb = fifo_glb[rd_ptr];

    // Control state: pointers, occupancy and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            inflight_o    <= '0;
            pred_v_o      <= 1'b0;
            pred_taken_o  <= 1'b0;
            resolve_err_o <= 1'b0;
        end else begin
            pred_v_o      <= push;
            resolve_err_o <= resolve_v_i & (inflight_o == '0);
            if (push) begin
                pred_taken_o <= final_pred;
            end
            if (flush_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                inflight_o <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                inflight_o <= inflight_o + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO payload storage; contents are don't-care while not in flight.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_idx[wr_ptr] <= idx;
            fifo_loc[wr_ptr] <= local_pred_i;
            fifo_glb[wr_ptr] <= global_pred_i;
            fifo_fin[wr_ptr] <= final_pred;
        end
    end

    // Chooser training: only disagreeing components move the counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(NCTR); i++) begin
                ctr[i] <= 2'd1;
            end
        end else if (pop && (pop_loc != pop_glb)) begin
            if (pop_glb == resolve_taken_i) begin
                if (ctr[pop_idx] != 2'd3) ctr[pop_idx] <= ctr[pop_idx] + 2'd1;
            end else begin
                if (ctr[pop_idx] != 2'd0) ctr[pop_idx] <= ctr[pop_idx] - 2'd1;
            end
        end
    end

`ifdef TOURNAMENT_CHOOSER_STATS_EN
    // Saturating count of resolved branches whose final prediction was wrong.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_mispred_o <= '0;
        end else if (pop && (fifo_fin[rd_ptr] != resolve_taken_i) &&
                     (stat_mispred_o != 16'hFFFF)) begin
            stat_mispred_o <= stat_mispred_o + 16'd1;
        end
    end
`else
    logic unused_fin;
    assign unused_fin = fifo_fin[rd_ptr];
`endif

endmodule

// File: tb/tb_tournament_chooser.sv
// Directed, table-driven bench for tournament_chooser (default parameters).
module tb_tournament_chooser;

    logic        clk = 1'b0;
    logic        reset_i, pred_v_i, local_pred_i, global_pred_i;
    logic [31:0] pred_pc_i;
    logic        resolve_v_i, resolve_taken_i, flush_i;
    logic        pred_ready_o, pred_v_o, pred_taken_o, resolve_err_o;
    logic [2:0]  inflight_o;
`ifdef TOURNAMENT_CHOOSER_STATS_EN
    logic [15:0] stat_mispred_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    tournament_chooser dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .pred_v_i        (pred_v_i),
        .pred_pc_i       (pred_pc_i),
        .local_pred_i    (local_pred_i),
        .global_pred_i   (global_pred_i),
        .pred_ready_o    (pred_ready_o),
        .pred_v_o        (pred_v_o),
        .pred_taken_o    (pred_taken_o),
        .resolve_v_i     (resolve_v_i),
        .resolve_taken_i (resolve_taken_i),
        .flush_i         (flush_i),
        .inflight_o      (inflight_o),
`ifdef TOURNAMENT_CHOOSER_STATS_EN
        .stat_mispred_o  (stat_mispred_o),
`endif
        .resolve_err_o   (resolve_err_o)
    );

    always #5 clk = ~clk;

    // ctl = {reset, pred_v, local, global, resolve_v, resolve_taken, flush}
    // exp = {pred_v_o, pred_taken_o, pred_ready_o, inflight_o[2:0], resolve_err_o}
    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] pc;
        logic [6:0]  exp;
    } vec_t;

    vec_t vt[26];

    function automatic vec_t mk(input logic [6:0] c, input logic [31:0] pc, input logic [6:0] e);
        vec_t v;
        v.ctl = c;
        v.pc  = pc;
        v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle just after the edge.
    task automatic step(input logic [6:0] c, input logic [31:0] pc);
        {reset_i, pred_v_i, local_pred_i, global_pred_i,
         resolve_v_i, resolve_taken_i, flush_i} = c;
        pred_pc_i = pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, REQ-028 lookup, reset mid-flight
        vt[0]  = mk(7'b1000000, 32'h100, 7'b0010000);
        vt[1]  = mk(7'b0110000, 32'h100, 7'b1110010);
        vt[2]  = mk(7'b1000000, 32'h100, 7'b0010000);
        // Train idx0 toward global: two lookups, two taken resolves
        vt[3]  = mk(7'b0101000, 32'h100, 7'b1010010);
        vt[4]  = mk(7'b0101000, 32'h100, 7'b1010100);
        vt[5]  = mk(7'b0000110, 32'h100, 7'b0010010);
        vt[6]  = mk(7'b0000110, 32'h100, 7'b0010000);
        vt[7]  = mk(7'b0101000, 32'h100, 7'b1110010);
        vt[8]  = mk(7'b0000110, 32'h100, 7'b0110000);
        // Resolve while empty: one-cycle error pulse, counters untouched
        vt[9]  = mk(7'b0000110, 32'h100, 7'b0110001);
        vt[10] = mk(7'b0000000, 32'h100, 7'b0110000);
        vt[11] = mk(7'b0101000, 32'h100, 7'b1110010);
        // Fill FIFO, refuse 5th, refuse while resolving from full
        vt[12] = mk(7'b0110000, 32'h104, 7'b1110100);
        vt[13] = mk(7'b0110000, 32'h104, 7'b1110110);
        vt[14] = mk(7'b0110000, 32'h104, 7'b1101000);
        vt[15] = mk(7'b0100000, 32'h104, 7'b0101000);
        vt[16] = mk(7'b0100110, 32'h104, 7'b0110110);
        // Flush with push and pop at inflight 3; idx1 must stay at 1
        vt[17] = mk(7'b0100101, 32'h104, 7'b0110000);
        vt[18] = mk(7'b0101000, 32'h104, 7'b1010010);
        vt[19] = mk(7'b0000110, 32'h104, 7'b0010000);
        vt[20] = mk(7'b0101000, 32'h104, 7'b1110010);
        vt[21] = mk(7'b0000100, 32'h104, 7'b0110000);
        vt[22] = mk(7'b0101000, 32'h104, 7'b1010010);
        // Simultaneous push and pop keeps occupancy
        vt[23] = mk(7'b0101100, 32'h100, 7'b1110010);
        vt[24] = mk(7'b0000110, 32'h100, 7'b0110000);
        // Reset wins over everything
        vt[25] = mk(7'b1101111, 32'h100, 7'b0010000);

        step(7'b0000000, 32'h0);
        for (int i = 0; i < 26; i++) begin
            step(vt[i].ctl, vt[i].pc);
            chk("pred_v",    i, 32'(pred_v_o),      32'(vt[i].exp[6]));
            chk("pred_taken",i, 32'(pred_taken_o),  32'(vt[i].exp[5]));
            chk("ready",     i, 32'(pred_ready_o),  32'(vt[i].exp[4]));
            chk("inflight",  i, 32'(inflight_o),    32'(vt[i].exp[3:1]));
            chk("res_err",   i, 32'(resolve_err_o), 32'(vt[i].exp[0]));
        end

        // Three lookups predicted taken (idx0 at 1 -> local=1), resolved not-taken
        for (int i = 0; i < 3; i++) begin
            step(7'b0110000, 32'h100);
            chk("seq_taken", 100 + i, 32'(pred_taken_o), 32'd1);
        end
        chk("seq_inflight", 103, 32'(inflight_o), 32'd3);
        for (int i = 0; i < 3; i++) step(7'b0000100, 32'h100);
        chk("seq_drained", 104, 32'(inflight_o), 32'd0);
`ifdef TOURNAMENT_CHOOSER_STATS_EN
        chk("stat_mispred", 105, 32'(stat_mispred_o), 32'd3);
        step(7'b0000100, 32'h100);
        chk("stat_hold_err", 106, 32'(stat_mispred_o), 32'd3);
        step(7'b1000000, 32'h100);
        chk("stat_reset", 107, 32'(stat_mispred_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tournament_chooser.md
TOURNAMENT_CHOOSER -- requirements
Module: tournament_chooser

Interface
REQ-001 SHALL have parameter IDX_W, default 6, giving chooser table depth 2^IDX_W.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the maximum number of in-flight predictions (power of 2, >=2).
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports pred_v_i input 1 and pred_pc_i input 32: lookup request and its fetch PC.
REQ-006 SHALL have ports local_pred_i input 1 and global_pred_i input 1: component predictions (two-level local and global) for the same PC, valid with pred_v_i.
REQ-007 SHALL have port pred_ready_o  output  1  lookup accepted when high.
REQ-008 SHALL have ports pred_v_o output 1 and pred_taken_o output 1: final registered prediction.
REQ-009 SHALL have ports resolve_v_i input 1 and resolve_taken_i input 1: actual outcome of the oldest in-flight branch.
REQ-010 SHALL have port flush_i  input  1  discard all in-flight entries.
REQ-011 SHALL have ports inflight_o output $clog2(FIFO_DEPTH)+1 (occupancy) and resolve_err_o output 1 (resolve with nothing in flight).

Function
REQ-012 SHALL hold 2^IDX_W 2-bit saturating chooser counters indexed by pred_pc_i[IDX_W+1:2]; value >=2 selects global, <2 selects local.
REQ-013 SHALL assert pred_ready_o = (inflight_o < FIFO_DEPTH) using registered occupancy only; there is no same-cycle bypass from resolve.
REQ-014 SHALL accept a lookup when pred_v_i & pred_ready_o; one cycle later pred_v_o=1 and pred_taken_o=selected component; otherwise pred_v_o=0 and pred_taken_o holds its last value.
REQ-015 SHALL read the counter value as registered before any same-cycle update (no write-to-read bypass).
REQ-016 SHALL push {index, local_pred_i, global_pred_i, final prediction} into an in-order FIFO on accept.
REQ-017 SHALL pop the oldest entry when resolve_v_i=1 and inflight_o>0.
REQ-018 SHALL update the popped entry's counter only if local!=global: increment (saturating at 3) if global==resolve_taken_i, decrement (saturating at 0) otherwise.
REQ-019 SHALL, on resolve_v_i=1 with inflight_o=0, leave state unchanged and pulse resolve_err_o for exactly one cycle (the registered cycle after).
REQ-020 SHALL leave inflight_o unchanged on a simultaneous push and pop, with both operations taking effect.
REQ-021 SHALL, on flush_i=1, empty the FIFO next cycle, discard same-cycle push and pop, suppress the counter update, leave counters intact, and force pred_v_o=0 next cycle.
REQ-022 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-023 SHALL, on reset_i, set all chooser counters to 1 (weakly local) over a single cycle.
REQ-024 SHALL, on reset_i, empty the FIFO and clear pred_v_o, pred_taken_o, resolve_err_o and inflight_o to 0.
REQ-025 SHALL give reset priority over flush, lookup and resolve; reset mid-operation discards all in-flight entries.

Configuration
REQ-026 SHALL, with TOURNAMENT_CHOOSER_STATS_EN defined, add output stat_mispred_o (16-bit) counting popped entries whose final prediction != resolve_taken_i, saturating at 0xFFFF and cleared by reset only.
REQ-027 SHALL, without TOURNAMENT_CHOOSER_STATS_EN, omit the stat_mispred_o port and its logic; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL cover: after reset, lookup pc=0x100 with local=1, global=0 -> pred_taken_o=1 next cycle (counter 1 selects local).
REQ-029 SHALL cover: 2 lookups at pc=0x100 (local=0, global=1), each resolved taken -> counter at idx 0 becomes 3; a third lookup gives pred_taken_o=1.
REQ-030 SHALL cover: 4 lookups without resolve -> inflight_o=4, pred_ready_o=0; a 5th request is not accepted and pred_v_o=0; same-cycle resolve and request -> request still refused that cycle.
REQ-031 SHALL cover: resolve_v_i=1 with inflight_o=0 -> resolve_err_o=1 for one cycle and counters unchanged.
REQ-032 SHALL cover: inflight_o=3, then flush_i together with pred_v_i and resolve_v_i -> inflight_o=0, pred_v_o=0, no counter change.
REQ-033 SHALL cover, with TOURNAMENT_CHOOSER_STATS_EN: 3 resolves against wrong predictions -> stat_mispred_o=3; reset -> 0.
